pin_issuer: RTL
===============

// Module: pin_issuer
// PURPOSE
//  Issuing end of the endgame PIN exchange: draws a pseudo-random 10-bit PIN, shows it on
//  the LEDs for a timed window, blanks them, then hands the PIN to the entry checker.
//  The PIN is held valid until the checker acknowledges or the game aborts the round.
// PARAMETERS
//  PIN_W       10             PIN width = LED/switch count
//  TICK_DIV    50_000_000     clk cycles per display tick (1 s at 50 MHz); must be >= 2
//  SHOW_TICKS  12             ticks the PIN stays visible; 0 = skip display
//  LFSR_SEED   10'h2A5        reset value of PIN LFSR; must be non-zero
// PORTS
//  clk        in   1      system clock
//  resetn     in   1      asynchronous, active-low reset
//  start      in   1      1-cycle request for a new PIN; honoured only in IDLE
//  abort      in   1      synchronous return to IDLE from any state
//  pin_ack    in   1      checker done with PIN; honoured only in ARMED
//  led        out  PIN_W  LED drive; PIN during SHOW, else 0
//  pin        out  PIN_W  issued PIN; stable from GEN until the next start
//  pin_valid  out  1      high in ARMED only
//  busy       out  1      high in GEN, SHOW and ARMED
//  secs_left  out  4      remaining display ticks; 0 outside SHOW
// BEHAVIOUR
//  - Reset (async): state=IDLE, lfsr=LFSR_SEED, all outputs 0.
//  - LFSR: 10-bit Galois, x^10+x^7+1. Advances every cycle in every state. Never reaches 0.
//  - IDLE: start & !abort -> GEN. pin <= lfsr.
//  - GEN: lasts 1 cycle. secs_left <= SHOW_TICKS. Divider <= 0. Next state is SHOW,
//    or ARMED if SHOW_TICKS==0.
//  - SHOW: led = pin (registered). Divider counts 0..TICK_DIV-1.
//    At terminal count: secs_left decrements.
//    When secs_left 1->0: led <= 0 and next state is ARMED.
//  - ARMED: led=0, pin_valid=1, pin held. pin_ack -> IDLE, pin_valid=0 on that edge.
//  - Latency: start sampled at edge n; led shows PIN after edge n+2.
//    PIN is visible for exactly SHOW_TICKS*TICK_DIV cycles.
//  - abort has priority over start, pin_ack and tick: next edge state=IDLE, led=0,
//    pin_valid=0, busy=0, secs_left=0. pin keeps its last value.
//  - start outside IDLE is ignored. pin_ack outside ARMED is ignored.
//  - start and pin_ack in the same cycle in ARMED: only pin_ack takes effect; start is dropped.
//  - Widths: divider is $clog2(TICK_DIV) bits. secs_left saturates at 0 and never wraps.
// CONFIGURATION
//  BLINK_WARN_EN defined: in SHOW while secs_left <= 3, led = pin for divider < TICK_DIV/2
//  and led = 0 otherwise (warning blink). Timing and all other outputs are unchanged.
//  Not defined: led steady at pin for the whole of SHOW.
// STRUCTURE
//  - Package pin_pkg: state enum {IDLE, GEN, SHOW, ARMED}, PIN_W default,
//    LFSR tap constant 10'h240.
//  - Sub-module sec_tick_gen: TICK_DIV divider with synchronous clear, 1-cycle tick output.
//    Cleared on GEN entry and on abort.
// TESTING (bench uses TICK_DIV=4, SHOW_TICKS=3)
//  1. Release resetn, start at first edge -> pin=10'h2A5 (or the LFSR value that cycle);
//     led=pin after 2 edges; led steady for 12 cycles; then led=0, pin_valid=1, secs_left=0.
//  2. Pulse start in SHOW and again in ARMED -> pin unchanged, no restart;
//     pin_ack -> pin_valid=0 and busy=0 on the next edge.
//  3. abort at secs_left=2 -> next edge led=0, busy=0, secs_left=0;
//     abort+start together in IDLE -> stays IDLE, busy=0.
//  4. resetn low mid-SHOW -> all outputs 0 immediately, without waiting for a clock edge;
//     after release, start works normally.
//  5. SHOW_TICKS=0, 1023 start/ack rounds at varied spacing -> GEN->ARMED directly,
//     led never non-zero, pin never 0.
//  6. BLINK_WARN_EN defined -> SHOW led pattern pin,pin,0,0 repeated 3 times;
//     undefined -> 12 cycles of pin.

Source files
------------

// File: rtl/pin_pkg.sv
// Shared types and constants for the PIN issuer: FSM states, default PIN width,
// and the Galois LFSR step for x^10 + x^7 + 1.
package pin_pkg;

    localparam int          PIN_W_DEF = 10;
    localparam int          LFSR_W    = 10;
    localparam logic [9:0]  LFSR_TAPS = 10'h240;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        SHOW  = 2'd2,
        ARMED = 2'd3
    } state_e;

    // Right-shifting Galois form; the feedback bit folds into taps 9 and 6.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] fb;
        fb = s[0] ? LFSR_TAPS : '0;
        return {1'b0, s[LFSR_W-1:1]} ^ fb;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Display-tick divider: counts 0..TICK_DIV-1 while enabled and emits a registered
// one-cycle tick after each wrap. With BLINK_WARN_EN defined it also flags the second half of each tick.
module sec_tick_gen
    import pin_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic blank_o
);

    localparam int                DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(TICK_DIV / 2);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (clr_i) begin
            div_d = '0;
        end else if (en_i) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef BLINK_WARN_EN
    assign blank_o = en_i && (div_q >= DIV_HALF);
`else
    assign blank_o = 1'b0;
`endif

endmodule

// File: rtl/pin_issuer.sv
// Issuing side of the PIN exchange: draws a PIN from a free-running LFSR, shows it
// for SHOW_TICKS display ticks, then holds it valid until acknowledged. Optional BLINK_WARN_EN.
module pin_issuer
    import pin_pkg::*;
#(
    parameter int          PIN_W      = PIN_W_DEF,
    parameter int          TICK_DIV   = 50_000_000,
    parameter int          SHOW_TICKS = 12,
    parameter logic [9:0]  LFSR_SEED  = 10'h2A5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             pin_ack,
    output logic [PIN_W-1:0] led,
    output logic [PIN_W-1:0] pin,
    output logic             pin_valid,
    output logic             busy,
    output logic [3:0]       secs_left
);

    state_e             state_q;
    state_e             state_d;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [PIN_W-1:0]   pin_q;
    logic [PIN_W-1:0]   pin_d;
    logic [PIN_W-1:0]   led_q;
    logic [PIN_W-1:0]   led_d;
    logic [3:0]         secs_q;
    logic [3:0]         secs_d;
    logic [PIN_W-1:0]   show_led;
    logic               tick;
    logic               blank;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .resetn  (resetn),
        .clr_i   ((state_q == GEN) || abort),
        .en_i    (state_q == SHOW),
        .tick_o  (tick),
        .blank_o (blank)
    );

    // Warning blink only applies during the last three ticks of the display window.
    assign show_led = (blank && (secs_q <= 4'd3)) ? '0 : pin_q;

    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        led_d   = led_q;
        secs_d  = secs_q;
        unique case (state_q)
            IDLE: begin
                led_d  = '0;
                secs_d = 4'd0;
                if (start) begin
                    state_d = GEN;
                    pin_d   = PIN_W'(lfsr_q);
                end
            end
            GEN: begin
                led_d   = '0;
                secs_d  = 4'(SHOW_TICKS);
                state_d = (SHOW_TICKS == 0) ? ARMED : SHOW;
            end
            SHOW: begin
                led_d = show_led;
                if (tick && (secs_q != 4'd0)) begin
                    secs_d = secs_q - 4'd1;
                    if (secs_q == 4'd1) begin
                        led_d   = '0;
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                led_d = '0;
                if (pin_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = '0;
                secs_d  = 4'd0;
            end
        endcase
        // Abort wins over everything but leaves the last PIN readable.
        if (abort) begin
            state_d = IDLE;
            led_d   = '0;
            secs_d  = 4'd0;
            pin_d   = pin_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            pin_q   <= '0;
            led_q   <= '0;
            secs_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_step(lfsr_q);
            pin_q   <= pin_d;
            led_q   <= led_d;
            secs_q  <= secs_d;
        end
    end

    assign led       = led_q;
    assign pin       = pin_q;
    assign pin_valid = (state_q == ARMED);
    assign busy      = (state_q != IDLE);
    assign secs_left = secs_q;

endmodule
